// File: rtl/matriz_scan_driver.sv
// matriz_scan_driver: row-multiplexed LED matrix scanner with blanking gaps and a per-frame shadow latch
module matriz_scan_driver #(
  parameter int ROWS = 6,
  parameter int COLS = 6,
  parameter int DWELL_CYCLES = 5000,
  parameter int BLANK_CYCLES = 50,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic                 clock,
  input  logic                 restart,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] leds,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_data,
  output logic [RW-1:0]        row_idx,
  output logic                 frame_done
);
  localparam int CMAX = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {LOAD, BLANK, SHOW} state_t;
  state_t state, state_n, first_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] idx_n;
  logic [ROWS*COLS-1:0] shadow, shadow_n;
  logic fd_n;
  logic [ROWS-1:0] row_sel_n;
  logic [COLS-1:0] col_n;
  always_comb begin
    first_n = BLANK_CYCLES == 0 ? SHOW : BLANK;
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = row_idx;
    shadow_n = shadow;
    fd_n = 1'b0;
    if (!enable) begin
      state_n = LOAD;
      cnt_n = '0;
      idx_n = '0;
    end else begin
      case (state)
        LOAD: begin
          shadow_n = leds;
          idx_n = '0;
          cnt_n = '0;
          state_n = first_n;
        end
        BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_n = SHOW;
          cnt_n = '0;
        end
        SHOW: if (cnt == CW'(DWELL_CYCLES - 1)) begin
          cnt_n = '0;
          fd_n = row_idx == RW'(ROWS - 1);
          idx_n = fd_n ? '0 : row_idx + 1'b1;
          state_n = fd_n ? LOAD : first_n;
        end
        default: state_n = LOAD;
      endcase
    end
    // outputs are decoded from next-state so they line up with the phase they belong to
    row_sel_n = state_n == SHOW ? ROWS'(1) << idx_n : '0;
    col_n = state_n == SHOW ? shadow_n[idx_n*COLS +: COLS] : '0;
  end
  always_ff @(posedge clock) begin
    if (restart) begin
      state <= LOAD;
      cnt <= '0;
      row_idx <= '0;
      shadow <= '0;
      frame_done <= 1'b0;
      row_sel <= '0;
      col_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      row_idx <= idx_n;
      shadow <= shadow_n;
      frame_done <= fd_n;
      row_sel <= row_sel_n;
      col_data <= col_n;
    end
  end
endmodule

// File: tb/tb_matriz_scan_driver.sv
// tb_matriz_scan_driver: directed checks of row mapping, tear-free latching, zero blank, enable drop and restart
module tb_matriz_scan_driver;
  logic clock = 1'b0;
  logic restart, enable;
  logic [35:0] leds;
  logic [5:0] row_sel, col_data, row_sel0, col_data0;
  logic [2:0] row_idx, row_idx0;
  logic frame_done, frame_done0;
  int vectors = 0, miscompares = 0, cyc = 0, fd_cnt = 0;

  always #5 clock = ~clock;

  matriz_scan_driver #(.ROWS(6), .COLS(6), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clock(clock), .restart(restart), .enable(enable), .leds(leds),
    .row_sel(row_sel), .col_data(col_data), .row_idx(row_idx), .frame_done(frame_done));

  matriz_scan_driver #(.ROWS(6), .COLS(6), .DWELL_CYCLES(3), .BLANK_CYCLES(0)) dut0 (
    .clock(clock), .restart(restart), .enable(enable), .leds(36'hF_FFFF_FFFF),
    .row_sel(row_sel0), .col_data(col_data0), .row_idx(row_idx0), .frame_done(frame_done0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    fd_cnt += int'(frame_done);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  always @(negedge clock) begin
    assert ($onehot0(row_sel) && (row_sel != 0 || col_data == 0) &&
            $onehot0(row_sel0) && (row_sel0 != 0 || col_data0 == 0)) else begin
      miscompares++;
      $error("FAIL invariant: row_sel %b col_data %b row_sel0 %b col_data0 %b", row_sel, col_data, row_sel0, col_data0);
    end
  end

  initial begin
    restart = 1'b1;
    enable = 1'b1;
    leds = 36'h8_0000_0001;
    repeat (2) begin @(posedge clock); #1; end
    chk("reset_row_sel", row_sel, 0);
    chk("reset_col_data", col_data, 0);
    chk("reset_row_idx", row_idx, 0);
    chk("reset_frame_done", frame_done, 0);
    restart = 1'b0;
    run_to(1);
    chk("blank1", row_sel, 0);
    chk("z_row0_sel", row_sel0, 6'b000001);
    chk("z_row0_col", col_data0, 6'b111111);
    run_to(2);
    chk("blank2", row_sel, 0);
    run_to(3);
    chk("row0_sel_start", row_sel, 6'b000001);
    chk("row0_col_start", col_data, 6'b000001);
    chk("row0_idx", row_idx, 0);
    run_to(4);
    chk("z_row1_nogap", row_sel0, 6'b000010);
    chk("z_row1_col", col_data0, 6'b111111);
    run_to(6);
    chk("row0_sel_end", row_sel, 6'b000001);
    run_to(7);
    chk("row1_blank_sel", row_sel, 0);
    chk("row1_blank_col", col_data, 0);
    chk("row1_blank_idx", row_idx, 1);
    run_to(9);
    chk("row1_sel", row_sel, 6'b000010);
    chk("row1_col", col_data, 0);
    run_to(18);
    chk("z_row5_sel", row_sel0, 6'b100000);
    run_to(19);
    chk("z_frame_done", frame_done0, 1);
    chk("z_load_dark", row_sel0, 0);
    run_to(20);
    chk("z_fd_single", frame_done0, 0);
    chk("z_next_row0", row_sel0, 6'b000001);
    run_to(33);
    chk("row5_sel", row_sel, 6'b100000);
    chk("row5_col", col_data, 6'b100000);
    chk("row5_idx", row_idx, 5);
    run_to(36);
    chk("row5_sel_end", row_sel, 6'b100000);
    chk("no_early_fd", fd_cnt, 0);
    run_to(37);
    chk("frame_done_37", frame_done, 1);
    chk("load_dark", row_sel, 0);
    chk("load_idx", row_idx, 0);
    run_to(38);
    chk("z_period_19", frame_done0, 1);
    chk("fd_pulse_once", frame_done, 0);
    run_to(53);
    chk("f2_row2_sel", row_sel, 6'b000100);
    leds = 36'hF_FFFF_FFFF;
    run_to(54);
    chk("f2_row2_old", col_data, 0);
    run_to(70);
    chk("f2_row5_sel", row_sel, 6'b100000);
    chk("f2_row5_old", col_data, 6'b100000);
    run_to(74);
    chk("f2_frame_done", frame_done, 1);
    chk("f2_fd_cnt", fd_cnt, 2);
    run_to(77);
    chk("f3_row0_sel", row_sel, 6'b000001);
    chk("f3_row0_new", col_data, 6'b111111);
    run_to(95);
    chk("f3_row3_sel", row_sel, 6'b001000);
    chk("f3_row3_new", col_data, 6'b111111);
    run_to(96);
    enable = 1'b0;
    leds = 36'h0_0000_0015;
    run_to(97);
    chk("dis_row_sel", row_sel, 0);
    chk("dis_col_data", col_data, 0);
    chk("dis_row_idx", row_idx, 0);
    chk("dis_no_fd", frame_done, 0);
    run_to(100);
    chk("dis_hold_dark", row_sel, 0);
    enable = 1'b1;
    run_to(101);
    chk("reen_blank", row_sel, 0);
    run_to(103);
    chk("reen_row0_sel", row_sel, 6'b000001);
    chk("reen_fresh_col", col_data, 6'h15);
    run_to(109);
    chk("reen_row1_sel", row_sel, 6'b000010);
    chk("reen_row1_col", col_data, 0);
    run_to(127);
    chk("row4_sel", row_sel, 6'b010000);
    chk("row4_idx", row_idx, 4);
    run_to(128);
    restart = 1'b1;
    run_to(129);
    chk("rst_row_sel", row_sel, 0);
    chk("rst_col_data", col_data, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_no_fd", frame_done, 0);
    chk("rst_fd_cnt", fd_cnt, 2);
    restart = 1'b0;
    run_to(165);
    chk("rst_no_early_fd", fd_cnt, 2);
    run_to(166);
    chk("rst_full_period_fd", frame_done, 1);
    chk("rst_fd_cnt_final", fd_cnt, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/matriz_scan_driver.md
Name: matriz_scan_driver

Overview:
- Consumer end of the 6x6 LED frame vector produced by the snake game's matrix logic.
- Takes the flat frame vector and time-multiplexes it onto a physical row/column LED matrix, one row at a time.
- Each row is preceded by a blanking gap to suppress ghosting.
- The frame is shadow-latched once per scan, so mid-scan updates from game logic never tear the display.

Parameters:
- ROWS, 6, number of matrix rows
- COLS, 6, number of matrix columns
- DWELL_CYCLES, 5000, clocks each row is lit; must be >= 1
- BLANK_CYCLES, 50, clocks all outputs are dark before each row; 0 allowed, meaning no blank phase

Ports:
- clock  input  1  system clock; all logic on rising edge
- restart  input  1  synchronous, active-high reset
- enable  input  1  scan enable; low forces dark outputs and holds the FSM in LOAD
- leds  input  ROWS*COLS  frame vector; bit r*COLS+c is row r, column c, 1 = lit
- row_sel  output  ROWS  one-hot active-high row drive
- col_data  output  COLS  active-high column data for the selected row
- row_idx  output  $clog2(ROWS)  index of the row currently lit or about to be lit
- frame_done  output  1  one-clock pulse when a full scan completes

Behaviour:
- Clock and reset: one clock (clock). restart is synchronous and active-high; it takes effect on the next rising edge and overrides everything, including enable.
- Reset values: row_sel=0, col_data=0, row_idx=0, frame_done=0, shadow=0, state=LOAD, counter=0.
- Output timing: all outputs are registered and change only on clock edges.
- LOAD state:
  - Outputs are dark.
  - If enable=1, on the next edge: shadow<=leds, row_idx<=0, counter<=0, state<=BLANK. If BLANK_CYCLES=0, go directly to SHOW instead.
  - If enable=0, remain in LOAD.
- BLANK state:
  - row_sel=0 and col_data=0 for exactly BLANK_CYCLES clocks.
  - Then move to SHOW with counter cleared.
- SHOW state:
  - row_sel=one-hot(row_idx) and col_data=shadow[row_idx*COLS +: COLS] for exactly DWELL_CYCLES clocks.
  - At the end of the dwell:
    - If row_idx < ROWS-1: row_idx increments and the FSM moves to BLANK (or straight back to SHOW when BLANK_CYCLES=0).
    - If row_idx = ROWS-1: row_idx<=0, state<=LOAD, and frame_done=1 during that single LOAD cycle.
- frame_done rules:
  - Asserts only after a completed last row.
  - Never asserts on the first LOAD after restart, nor on LOAD entered because enable dropped.
- Frame period: 1 + ROWS*(BLANK_CYCLES+DWELL_CYCLES) clocks. With defaults this is 30301.
- Invariants:
  - row_sel is never multi-hot.
  - row_sel and col_data are both zero whenever row_sel=0, so there are no column glitches during blank.
- Tear-free display: leds is sampled only in LOAD. Changes to leds during BLANK/SHOW are not visible until the next frame.
- enable deasserted mid-scan:
  - Next edge: outputs go dark, state<=LOAD, row_idx<=0, counter<=0, no frame_done.
  - On re-enable, the scan restarts at row 0 with a fresh capture.
- Counter: width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1). It saturates nowhere and wraps nowhere, because it is cleared on every phase change.
- restart mid-row: next edge gives reset values; the partially displayed frame is discarded.

Test Plan:
- Basic row mapping (DWELL_CYCLES=4, BLANK_CYCLES=2, leds=36'h8_0000_0001):
  - Release restart with enable=1.
  - Row 0 shows row_sel=6'b000001, col_data=6'b000001 for 4 clocks, starting 3 clocks after LOAD.
  - Row 5 shows row_sel=6'b100000, col_data=6'b100000.
  - frame_done pulses once at clock 37 after LOAD; period measured is 37.
- Mid-frame change: change leds to all-ones during row 2 SHOW -> rows 2..5 still show the old shadow; the next frame shows col_data=6'b111111 on every row.
- Zero blank (BLANK_CYCLES=0, DWELL_CYCLES=3, leds=0xFFFFFFFFF) -> row_sel advances every 3 clocks with no dark gap; frame period is 19.
- Enable drop: drop enable during row 3 -> row_sel=0 next edge, no frame_done; re-enable -> LOAD then row 0, fresh capture.
- Mid-scan restart: assert restart during row 4 SHOW -> all outputs 0 next edge, row_idx=0; the first frame_done appears a full period after release.
- Continuous checker: every cycle, row_sel is one-hot or zero, and col_data=0 whenever row_sel=0.
